// File: rtl/result_reader_pkg.sv
// Shared definitions for the result reader: default geometry, derived widths
// and the readout FSM state encoding.
package result_reader_pkg;

  localparam int NUM_ROWS_DEF      = 128;
  localparam int ROW_W_DEF         = 1024;
  localparam int WORD_W_DEF        = 32;
  localparam int ADDR_W_DEF        = $clog2(NUM_ROWS_DEF);
  localparam int WORDS_PER_ROW_DEF = ROW_W_DEF / WORD_W_DEF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    STREAM = 3'd3,
    FINISH = 3'd4
  } state_t;

  // Width of a counter indexing 0..count-1; at least one bit so single-entry
  // geometries still produce a legal vector.
  function automatic int addr_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/result_reader_row_serializer.sv
// Holds one result row and presents it word by word, least-significant word
// first. The word index only advances on an accepted word and never wraps;
// a fresh load restarts it at zero.
module result_reader_row_serializer
  import result_reader_pkg::*;
#(
  parameter int ROW_W  = ROW_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ROW_W-1:0]  row_in,
  input  logic              advance,
  output logic [WORD_W-1:0] word,
  output logic              last_word
);

  localparam int WORDS  = ROW_W / WORD_W;
  localparam int WIDX_W = addr_width(WORDS);
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(WORDS - 1);

  logic [ROW_W-1:0]  row_reg;
  logic [WIDX_W-1:0] idx_reg;
  logic [WORD_W-1:0] words [WORDS];

  // Row capture and word index stepping
  always_ff @(posedge clk) begin
    if (reset) begin
      row_reg <= '0;
      idx_reg <= '0;
    end else if (load) begin
      row_reg <= row_in;
      idx_reg <= '0;
    end else if (advance && !last_word) begin
      idx_reg <= idx_reg + 1'b1;
    end
  end

  // Split the row into word lanes; the selected lane is a pure function of
  // registered state, so downstream ready never reaches the data path.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_lane
      assign words[gi] = row_reg[gi*WORD_W +: WORD_W];
    end
  endgenerate

  assign word      = words[idx_reg];
  assign last_word = (idx_reg == LAST_IDX);

endmodule

// File: rtl/result_reader.sv
// Reads NUM_ROWS rows from the result BRAM and streams each row out as
// WORD_W-bit words over a valid/ready interface, flagging the final word of
// the final row and pulsing done once the whole readout has been accepted.
module result_reader
  import result_reader_pkg::*;
#(
  parameter int NUM_ROWS = NUM_ROWS_DEF,
  parameter int ROW_W    = ROW_W_DEF,
  parameter int WORD_W   = WORD_W_DEF,
  localparam int ADDR_W  = addr_width(NUM_ROWS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  input  logic [ROW_W-1:0]  ram_dout,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] row_reg;
  logic              row_load;
  logic              transfer;
  logic              last_word;
  logic [WORD_W-1:0] word_data;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and Moore outputs; start is only looked at in IDLE
  always_comb begin
    state_next = state_reg;
    ram_en     = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;
    row_load   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        ram_en     = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        row_load   = 1'b1;
        state_next = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        if (out_ready && last_word)
          state_next = (row_reg == LAST_ROW) ? FINISH : FETCH;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign transfer = out_valid && out_ready;

  // Row counter: cleared on an accepted start, stepped after each row's final
  // word is accepted, held at the last row so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      row_reg <= '0;
    end else if (transfer && last_word && row_reg != LAST_ROW) begin
      row_reg <= row_reg + 1'b1;
    end
  end

  result_reader_row_serializer #(
    .ROW_W  (ROW_W),
    .WORD_W (WORD_W)
  ) u_row_serializer (
    .clk       (clk),
    .reset     (reset),
    .load      (row_load),
    .row_in    (ram_dout),
    .advance   (transfer),
    .word      (word_data),
    .last_word (last_word)
  );

  assign ram_addr = row_reg;
  assign busy     = (state_reg != IDLE);
  // Data is forced to zero when not presenting so idle/reset outputs are clean.
  assign out_data = out_valid ? word_data : '0;
  assign out_last = out_valid && last_word && (row_reg == LAST_ROW);

endmodule

// File: tb/tb_result_reader.sv
// Bench for result_reader: a default-geometry instance fed by a BRAM model
// whose row r holds words r*32+w, and a two-row/two-word instance whose row r
// holds words 100+2r+w. Expected words are queued when start is driven and
// popped as the DUT hands words over.
module tb_result_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [6:0]    ram_addr;
  logic          ram_en;
  logic [1023:0] ram_dout = '0;
  logic [31:0]   out_data;
  logic          out_valid, out_last, busy, done;

  logic          start_s = 1'b0;
  logic          ready_s = 1'b0;
  logic [0:0]    ram_addr_s;
  logic          ram_en_s;
  logic [63:0]   ram_dout_s = '0;
  logic [31:0]   out_data_s;
  logic          out_valid_s, out_last_s, busy_s, done_s;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  result_reader dut (
    .clk(clk), .reset(reset), .start(start), .ram_addr(ram_addr), .ram_en(ram_en),
    .ram_dout(ram_dout), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  result_reader #(.NUM_ROWS(2), .ROW_W(64), .WORD_W(32)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .ram_addr(ram_addr_s), .ram_en(ram_en_s),
    .ram_dout(ram_dout_s), .out_data(out_data_s), .out_valid(out_valid_s),
    .out_ready(ready_s), .out_last(out_last_s), .busy(busy_s), .done(done_s)
  );

  // BRAM models with one-cycle registered read
  always @(posedge clk) begin
    if (ram_en)
      for (int w = 0; w < 32; w++) ram_dout[w*32 +: 32] <= 32'(int'(ram_addr) * 32 + w);
    if (ram_en_s)
      for (int w = 0; w < 2; w++) ram_dout_s[w*32 +: 32] <= 32'(100 + int'(ram_addr_s) * 2 + w);
  end

  task automatic do_reset;
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; start_s = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; start_s = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ram_addr !== 7'd0) begin errors++; $display("FAIL reset_ram_addr: got %0d want 0", ram_addr); end
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en: got %b want 0", ram_en); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL reset_busy_small: got %b want 0", busy_s); end
    start = 1'b0; start_s = 1'b0; reset = 1'b0;
    $display("test_reset: done");
  endtask

  // Full readout with ready held high: order, last flag, exact cycle of every
  // word (2 + 34*row + word), BRAM address sequence, busy span and done timing.
  task automatic test_full_stream;
    int nxt_row, en_cnt, last_k, done_cnt, exp_w;
    bit exp_busy;
    exp_q.delete();
    for (int i = 0; i < 4096; i++) exp_q.push_back(i);
    nxt_row = 0; en_cnt = 0; last_k = -1; done_cnt = 0;
    start = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 6000; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (ram_en) begin
        checks++;
        if (ram_addr !== 7'(nxt_row)) begin errors++; $display("FAIL full_ram_addr: got %0d want %0d", ram_addr, nxt_row); end
        nxt_row++; en_cnt++;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL full_extra_word: got %0d want none", out_data);
        end else begin
          exp_w = exp_q.pop_front();
          checks++; if (out_data !== 32'(exp_w)) begin errors++; $display("FAIL full_data: got %0d want %0d", out_data, exp_w); end
          checks++; if (out_last !== (exp_w == 4095)) begin errors++; $display("FAIL full_last: word %0d got %b want %b", exp_w, out_last, exp_w == 4095); end
          checks++; if (k != 2 + (exp_w / 32) * 34 + exp_w % 32) begin errors++; $display("FAIL full_timing: word %0d at cycle %0d want %0d", exp_w, k, 2 + (exp_w / 32) * 34 + exp_w % 32); end
          if (exp_w == 4095) last_k = k;
        end
      end
      if (done) begin
        done_cnt++;
        checks++; if (k != last_k + 1) begin errors++; $display("FAIL full_done_timing: got cycle %0d want %0d", k, last_k + 1); end
      end
      exp_busy = !(done_cnt > 0 && !done);
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL full_busy: cycle %0d got %b want %b", k, busy, exp_busy); end
      if (done_cnt > 0 && !done) break;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_missing_words: got %0d left want 0", exp_q.size()); end
    checks++; if (en_cnt != 128) begin errors++; $display("FAIL full_ram_en_count: got %0d want 128", en_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_done_count: got %0d want 1", done_cnt); end
    $display("test_full_stream: %0d ram_en pulses, last word at cycle %0d", en_cnt, last_k);
  endtask

  // Random backpressure: same word sequence, outputs frozen during each stall
  task automatic test_backpressure;
    int done_cnt, exp_w, stalls;
    bit stalled;
    logic [31:0] held_data;
    logic held_last;
    exp_q.delete();
    for (int i = 0; i < 4096; i++) exp_q.push_back(i);
    done_cnt = 0; stalled = 1'b0; stalls = 0; held_data = '0; held_last = 1'b0;
    start = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 15000; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_data || out_last !== held_last) begin
          errors++;
          $display("FAIL bp_stall_stable: got v=%b d=%0d l=%b want v=1 d=%0d l=%b", out_valid, out_data, out_last, held_data, held_last);
        end
      end
      out_ready = ($urandom_range(0, 99) >= 30);
      if (out_valid && out_ready) begin
        stalled = 1'b0;
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL bp_extra_word: got %0d want none", out_data);
        end else begin
          exp_w = exp_q.pop_front();
          checks++; if (out_data !== 32'(exp_w)) begin errors++; $display("FAIL bp_data: got %0d want %0d", out_data, exp_w); end
          checks++; if (out_last !== (exp_w == 4095)) begin errors++; $display("FAIL bp_last: word %0d got %b want %b", exp_w, out_last, exp_w == 4095); end
        end
      end else if (out_valid) begin
        stalled = 1'b1; stalls++; held_data = out_data; held_last = out_last;
      end
      if (done) begin
        done_cnt++;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_early_done: got %0d words left want 0", exp_q.size()); end
      end
      if (done_cnt > 0 && !done) break;
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
    out_ready = 1'b1;
    $display("test_backpressure: %0d stall cycles, %0d words left", stalls, exp_q.size());
  endtask

  // Reset while presenting row 5 word 10, then restart from row 0
  task automatic test_reset_mid;
    int exp_w;
    bit hit;
    exp_q.delete();
    for (int i = 0; i < 4096; i++) exp_q.push_back(i);
    hit = 1'b0;
    start = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 400 && !hit; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (out_valid && exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        checks++; if (out_data !== 32'(exp_w)) begin errors++; $display("FAIL rm_data: got %0d want %0d", out_data, exp_w); end
        if (exp_w == 5 * 32 + 10) begin hit = 1'b1; reset = 1'b1; end
      end
    end
    checks++; if (!hit) begin errors++; $display("FAIL rm_reach_word: got no word 170 want word 170 within 400 cycles"); end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL rm_out_data: got %h want 0", out_data); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rm_out_last: got %b want 0", out_last); end
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL rm_ram_en: got %b want 0", ram_en); end
    checks++; if (ram_addr !== 7'd0) begin errors++; $display("FAIL rm_ram_addr: got %0d want 0", ram_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rm_done: got %b want 0", done); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_quiet: got done=%b busy=%b want 0 0", done, busy); end
    end
    for (int i = 0; i < 40; i++) exp_q.push_back(i);
    start = 1'b1;
    for (int k = 0; k < 80 && exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (out_valid) begin
        exp_w = exp_q.pop_front();
        checks++; if (out_data !== 32'(exp_w)) begin errors++; $display("FAIL rm_restart_data: got %0d want %0d", out_data, exp_w); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rm_restart_words: got %0d left want 0", exp_q.size()); end
    do_reset();
    $display("test_reset_mid: restart checked");
  endtask

  // start pulsed mid-row 3 and on the done cycle must be ignored; a start on
  // the following idle cycle is accepted
  task automatic test_start_ignored;
    int done_cnt, exp_w;
    exp_q.delete();
    for (int i = 0; i < 4096; i++) exp_q.push_back(i);
    done_cnt = 0;
    start = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 6000; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done_cnt > 0 && !done) break;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL si_extra_word: got %0d want none", out_data);
        end else begin
          exp_w = exp_q.pop_front();
          checks++; if (out_data !== 32'(exp_w)) begin errors++; $display("FAIL si_data: got %0d want %0d", out_data, exp_w); end
          if (exp_w == 3 * 32 + 16) start = 1'b1;
        end
      end
      if (done) begin done_cnt++; start = 1'b1; end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL si_done_count: got %0d want 1", done_cnt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL si_missing_words: got %0d left want 0", exp_q.size()); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (busy !== 1'b0 || ram_en !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL si_idle_after_done: got busy=%b ram_en=%b done=%b want 0 0 0", busy, ram_en, done); end
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1 || ram_en !== 1'b1 || ram_addr !== 7'd0) begin errors++; $display("FAIL si_accept_in_idle: got busy=%b ram_en=%b addr=%0d want 1 1 0", busy, ram_en, ram_addr); end
    do_reset();
    $display("test_start_ignored: %0d done pulses", done_cnt);
  endtask

  // Small geometry: 2 rows of 2 words, busy exactly from accept to done
  task automatic test_small;
    int last_k, done_cnt, exp_w, n;
    bit exp_busy;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(100 + i);
    last_k = -1; done_cnt = 0;
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL small_busy_before: got %b want 0", busy_s); end
    start_s = 1'b1; ready_s = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      start_s = 1'b0;
      if (out_valid_s) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL small_extra_word: got %0d want none", out_data_s);
        end else begin
          exp_w = exp_q.pop_front();
          n = exp_w - 100;
          checks++; if (out_data_s !== 32'(exp_w)) begin errors++; $display("FAIL small_data: got %0d want %0d", out_data_s, exp_w); end
          checks++; if (out_last_s !== (n == 3)) begin errors++; $display("FAIL small_last: word %0d got %b want %b", n, out_last_s, n == 3); end
          checks++; if (k != 2 + (n / 2) * 4 + n % 2) begin errors++; $display("FAIL small_timing: word %0d at cycle %0d want %0d", n, k, 2 + (n / 2) * 4 + n % 2); end
          if (n == 3) last_k = k;
        end
      end
      if (done_s) begin
        done_cnt++;
        checks++; if (k != last_k + 1) begin errors++; $display("FAIL small_done_timing: got cycle %0d want %0d", k, last_k + 1); end
      end
      exp_busy = !(done_cnt > 0 && !done_s);
      checks++; if (busy_s !== exp_busy) begin errors++; $display("FAIL small_busy: cycle %0d got %b want %b", k, busy_s, exp_busy); end
      if (done_cnt > 0 && !done_s) break;
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL small_done_count: got %0d want 1", done_cnt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL small_missing_words: got %0d left want 0", exp_q.size()); end
    $display("test_small: last word at cycle %0d", last_k);
  endtask

  initial begin
    test_reset();
    test_full_stream();
    test_backpressure();
    test_reset_mid();
    test_start_ignored();
    test_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_reader.md
RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 128, number of result rows to read from the result BRAM.
REQ-002 SHALL have parameter ROW_W, default 1024, result row width in bits.
REQ-003 SHALL have parameter WORD_W, default 32, output word width; ROW_W is a multiple of WORD_W.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  single-cycle pulse: begin readout of rows 0..NUM_ROWS-1.
REQ-007 SHALL have port ram_addr  output  7  result BRAM read address (log2 NUM_ROWS).
REQ-008 SHALL have port ram_en  output  1  result BRAM enable; ram_we tied 0 externally.
REQ-009 SHALL have port ram_dout  input  ROW_W  result BRAM read data, valid 1 cycle after ram_en with ram_addr.
REQ-010 SHALL have port out_data  output  WORD_W  streamed result word.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts word when out_valid and out_ready high.
REQ-013 SHALL have port out_last  output  1  high with the final word of row NUM_ROWS-1.
REQ-014 SHALL have port busy  output  1  high from cycle after accepted start until done.
REQ-015 SHALL have port done  output  1  one-cycle pulse after last word accepted.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, WAIT, STREAM, FINISH.
REQ-017 IDLE: start=1 -> FETCH, row counter := 0; start ignored in every other state.
REQ-018 FETCH: drive ram_en=1, ram_addr=row counter for exactly one cycle -> WAIT.
REQ-019 WAIT: capture ram_dout into row register at end of cycle, word index := 0 -> STREAM.
REQ-020 STREAM: out_valid=1, out_data = row_reg[word_idx*WORD_W +: WORD_W], least-significant word first.
REQ-021 Transfer occurs on cycle with out_valid && out_ready; out_data/out_last SHALL hold stable while out_valid && !out_ready.
REQ-022 On transfer of word ROW_W/WORD_W-1: if row counter = NUM_ROWS-1 -> FINISH, else row counter +1 -> FETCH.
REQ-023 out_last SHALL be high only while presenting word ROW_W/WORD_W-1 of row NUM_ROWS-1.
REQ-024 FINISH: done=1 for one cycle -> IDLE.
REQ-025 ram_en SHALL be 0 outside FETCH; out_valid SHALL be 0 outside STREAM.
REQ-026 Row counter and word index SHALL never wrap past NUM_ROWS-1 / ROW_W/WORD_W-1.
REQ-027 Row throughput with out_ready held high: ROW_W/WORD_W + 2 cycles per row; first out_valid 2 cycles after start accepted.
REQ-028 start coinciding with done cycle SHALL be ignored; start in IDLE on following cycle accepted.

Reset
REQ-029 reset=1 SHALL force state IDLE, row counter 0, word index 0, row register 0 on next edge, taking priority over start.
REQ-030 Reset values: ram_addr=0, ram_en=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0.
REQ-031 Reset mid-readout SHALL abandon the row with no done pulse; next start restarts at row 0.

Structure
REQ-032 Shared package SHALL hold NUM_ROWS, ROW_W, WORD_W defaults, derived ADDR_W and WORDS_PER_ROW, and the FSM state encoding.
REQ-033 Single module; one optional sub-module row_serializer (row register + word mux + word index) is natural.
REQ-034 Output regs registered; out_data driven from a registered row and registered index (no combinational path from out_ready to out_data).

Verification
REQ-035 BRAM model row r = {32 words each = r*32+w}; start, out_ready=1 -> 4096 words in order 0..4095, out_last on word 4095, done 1 cycle later.
REQ-036 Throughput: out_ready=1 -> 34 cycles per row, exactly 128 ram_en pulses, addresses 0..127 ascending.
REQ-037 Backpressure: out_ready random 30% low -> identical word sequence, out_data stable during every stall.
REQ-038 Reset asserted during row 5 word 10 -> all outputs 0 next cycle, no done; new start -> first word 0 from row 0.
REQ-039 start pulsed at row 3 mid-stream and on done cycle -> ignored; sequence and single done unchanged.
REQ-040 NUM_ROWS=2, ROW_W=64, WORD_W=32 -> 4 words, out_last on 4th, busy high exactly from accept to done.
